// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side buses of the cache/memory arbiter.
// master = the arbiter's view; slave = the caches and Data_Memory seen from outside.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              p0_enable_i;
   logic              p0_write_i;
   logic [ADDR_W-1:0] p0_addr_i;
   logic [LINE_W-1:0] p0_data_i;
   logic              p0_ack_o;
   logic [LINE_W-1:0] p0_data_o;

   logic              p1_enable_i;
   logic              p1_write_i;
   logic [ADDR_W-1:0] p1_addr_i;
   logic [LINE_W-1:0] p1_data_i;
   logic              p1_ack_o;
   logic [LINE_W-1:0] p1_data_o;

   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [LINE_W-1:0] mem_data_i;

   logic              busy_o;
   logic              timeout_o;

   modport master (
      input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
      output p0_ack_o, p0_data_o,
      input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
      output p1_ack_o, p1_data_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_ack_i, mem_data_i,
      output busy_o, timeout_o
   );

   modport slave (
      output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
      input  p0_ack_o, p0_data_o,
      output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
      input  p1_ack_o, p1_data_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_ack_i, mem_data_i,
      input  busy_o, timeout_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single 256-bit Data_Memory port between the I-cache
// (port 0) and the D-cache (port 1), one transaction at a time, all outputs
// registered. Default arbitration is fixed priority (port 1 wins); defining
// MEM_ARBITER_RR_EN switches to round-robin on simultaneous requests.
module mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int LINE_W         = 256,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.master bus
);

   localparam int               CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic              busy_q, busy_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_data_q, mem_data_d;
   logic              p0_ack_q, p0_ack_d;
   logic              p1_ack_q, p1_ack_d;
   logic [LINE_W-1:0] p0_data_q, p0_data_d;
   logic [LINE_W-1:0] p1_data_q, p1_data_d;
   logic              win;

`ifdef MEM_ARBITER_RR_EN
   logic              last_grant_q, last_grant_d;

   // Winner: on a tie the port that was not granted last time goes first
   always_comb begin
      win = bus.p1_enable_i & (~bus.p0_enable_i | ~last_grant_q);
   end

   // Remember the most recent grant; only moves when a grant is issued
   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == S_IDLE && (bus.p0_enable_i || bus.p1_enable_i)) last_grant_d = win;
   end

   // Round-robin history register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) last_grant_q <= 1'b0;
      else        last_grant_q <= last_grant_d;
   end
`else
   // Winner: the D-cache always beats the I-cache
   always_comb begin
      win = bus.p1_enable_i;
   end
`endif

   // Next-state and registered-output computation for the transaction FSM
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      mem_en_d   = mem_en_q;
      mem_wr_d   = mem_wr_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      p0_ack_d   = 1'b0;
      p1_ack_d   = 1'b0;
      p0_data_d  = p0_data_q;
      p1_data_d  = p1_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.p0_enable_i || bus.p1_enable_i) begin
               owner_d    = win;
               mem_en_d   = 1'b1;
               mem_wr_d   = win ? bus.p1_write_i : bus.p0_write_i;
               mem_addr_d = win ? bus.p1_addr_i  : bus.p0_addr_i;
               mem_data_d = win ? bus.p1_data_i  : bus.p0_data_i;
               cnt_d      = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // counter saturates at all-ones, which is never below TO_VAL
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (TIMEOUT_CYCLES != 0 && cnt_d >= TO_VAL) timeout_d = 1'b1;
            if (bus.mem_ack_i) begin
               mem_en_d = 1'b0;
               mem_wr_d = 1'b0;
               if (owner_q) p1_ack_d = 1'b1;
               else         p0_ack_d = 1'b1;
               // the read line is only captured for reads; writes leave data_o alone
               if (!mem_wr_q) begin
                  if (owner_q) p1_data_d = bus.mem_data_i;
                  else         p0_data_d = bus.mem_data_i;
               end
               state_d = S_RESP;
            end
         end
         S_RESP: state_d = S_HOLD;
         // dead cycle: lets the owner drop enable before the next arbitration
         S_HOLD: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         p0_ack_q   <= 1'b0;
         p1_ack_q   <= 1'b0;
         p0_data_q  <= '0;
         p1_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
         mem_en_q   <= mem_en_d;
         mem_wr_q   <= mem_wr_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         p0_ack_q   <= p0_ack_d;
         p1_ack_q   <= p1_ack_d;
         p0_data_q  <= p0_data_d;
         p1_data_q  <= p1_data_d;
      end
   end

   assign bus.mem_enable_o = mem_en_q;
   assign bus.mem_write_o  = mem_wr_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_data_o   = mem_data_q;
   assign bus.p0_ack_o     = p0_ack_q;
   assign bus.p1_ack_o     = p1_ack_q;
   assign bus.p0_data_o    = p0_data_q;
   assign bus.p1_data_o    = p1_data_q;
   assign bus.busy_o       = busy_q;
   assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-timeline model of the arbiter.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;
   localparam int TO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   // reference model: one transaction timeline (grant edge, ack edge)
   bit            m_in_txn, m_owner, m_wr, m_to, m_last;
   int            m_grant_e, m_ack_e, m_free_e;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata;
   logic [LW-1:0] m_pdata [2];
   bit            m_ack [2];

   // requester / memory agents
   bit            pend [2];
   bit            req_wr [2];
   logic [AW-1:0] req_addr [2];
   logic [LW-1:0] req_data [2];
   bit            auto_req, auto_mem, hold_req, stray;
   int            mem_dly = -1;
   bit            prev_en;
   int            obs_grants [$];

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, cyc);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic m_clear();
      m_in_txn = 0; m_owner = 0; m_wr = 0; m_to = 0; m_last = 0;
      m_grant_e = -1; m_ack_e = -1; m_free_e = 0;
      m_addr = '0; m_wdata = '0;
      m_pdata[0] = '0; m_pdata[1] = '0;
      m_ack[0] = 0; m_ack[1] = 0;
   endtask

   // apply the arbiter rules to the inputs present at this clock edge
   task automatic model_edge();
      bit w;
      if (!rst_n) begin
         m_clear();
         return;
      end
      m_ack[0] = 0;
      m_ack[1] = 0;
      if (m_in_txn && m_ack_e < 0 && cyc - m_grant_e >= TO) m_to = 1;
      if (!m_in_txn && cyc >= m_free_e && (bus.p0_enable_i || bus.p1_enable_i)) begin
         if (bus.p0_enable_i && bus.p1_enable_i) begin
`ifdef MEM_ARBITER_RR_EN
            w = !m_last;
`else
            w = 1'b1;
`endif
         end else begin
            w = bus.p1_enable_i;
         end
         m_last    = w;
         m_in_txn  = 1;
         m_owner   = w;
         m_grant_e = cyc;
         m_ack_e   = -1;
         m_wr      = w ? bus.p1_write_i : bus.p0_write_i;
         m_addr    = w ? bus.p1_addr_i  : bus.p0_addr_i;
         m_wdata   = w ? bus.p1_data_i  : bus.p0_data_i;
      end else if (m_in_txn && m_ack_e < 0 && bus.mem_ack_i) begin
         m_ack_e  = cyc;
         m_free_e = cyc + 3;
         m_ack[m_owner] = 1;
         if (!m_wr) m_pdata[m_owner] = bus.mem_data_i;
      end else if (m_in_txn && m_ack_e >= 0 && cyc == m_ack_e + 2) begin
         m_in_txn = 0;
      end
   endtask

   task automatic check_all();
      bit ws;
      ws = m_in_txn && m_ack_e < 0;
      chk("mem_enable", LW'(bus.mem_enable_o), LW'(ws));
      chk("mem_write",  LW'(bus.mem_write_o),  LW'(ws && m_wr));
      chk("mem_addr",   LW'(bus.mem_addr_o),   LW'(m_addr));
      chk("mem_data",   bus.mem_data_o,        m_wdata);
      chk("p0_ack",     LW'(bus.p0_ack_o),     LW'(m_ack[0]));
      chk("p1_ack",     LW'(bus.p1_ack_o),     LW'(m_ack[1]));
      chk("p0_data",    bus.p0_data_o,         m_pdata[0]);
      chk("p1_data",    bus.p1_data_o,         m_pdata[1]);
      chk("busy",       LW'(bus.busy_o),       LW'(m_in_txn));
      chk("timeout",    LW'(bus.timeout_o),    LW'(m_to));
      if (bus.mem_enable_o && !prev_en) obs_grants.push_back(int'(bus.mem_addr_o[AW-1]));
      prev_en = bus.mem_enable_o;
   endtask

   task automatic drive();
      bus.p0_enable_i = pend[0];   bus.p1_enable_i = pend[1];
      bus.p0_write_i  = req_wr[0]; bus.p1_write_i  = req_wr[1];
      bus.p0_addr_i   = req_addr[0]; bus.p1_addr_i = req_addr[1];
      bus.p0_data_i   = req_data[0]; bus.p1_data_i = req_data[1];
   endtask

   task automatic new_req(input int n, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
      pend[n] = 1; req_wr[n] = wr; req_addr[n] = a; req_data[n] = d;
   endtask

   // random request; address top bit tags the port so grants are identifiable
   task automatic rand_req(input int n);
      logic [AW-1:0] a;
      a = $urandom;
      a[AW-1] = n[0];
      a[4:0] = '0;
      new_req(n, bit'($urandom_range(0, 1)), a, rand_line());
   endtask

   task automatic agents();
      logic [1:0] ack;
      ack = {bus.p1_ack_o, bus.p0_ack_o};
      for (int n = 0; n < 2; n++) begin
         if (ack[n]) begin
            pend[n] = 0;
            if (hold_req) rand_req(n);
         end else if (!pend[n] && auto_req && $urandom_range(0, 3) == 0) begin
            rand_req(n);
         end
      end
      if (auto_mem) begin
         bus.mem_ack_i = 1'b0;
         if (bus.mem_enable_o) begin
            if (mem_dly < 0) mem_dly = $urandom_range(0, 5);
            else if (mem_dly == 0) begin
               bus.mem_ack_i  = 1'b1;
               bus.mem_data_i = rand_line();
               mem_dly = -1;
            end else mem_dly--;
         end else if (stray && $urandom_range(0, 9) == 0) begin
            bus.mem_ack_i  = 1'b1;
            bus.mem_data_i = rand_line();
         end
      end
      drive();
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_all();
      agents();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic mem_pulse(input logic [LW-1:0] d);
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = d;
      tick();
      bus.mem_ack_i  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pend[0] = 0; pend[1] = 0;
      auto_req = 0; auto_mem = 0; hold_req = 0; stray = 0; mem_dly = -1;
      bus.mem_ack_i = 1'b0;
      drive();
      ticks(2);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [LW-1:0] aa, ff55, bb;
      int need, g0, budget;
      aa   = {8{32'hAAAA_AAAA}};
      ff55 = {8{32'h5555_5555}};
      bb   = {8{32'hBBBB_BBBB}};
      m_clear();
      for (int n = 0; n < 2; n++) begin
         pend[n] = 0; req_wr[n] = 0; req_addr[n] = '0; req_data[n] = '0;
      end
      bus.mem_ack_i = 1'b0;
      bus.mem_data_i = '0;
      drive();
      #1;
      do_reset();

      // single read on port 0, memory acks after 10 cycles
      new_req(0, 0, 32'h0000_0400, '0);
      drive();
      tick();
      chk("t1_addr", LW'(bus.mem_addr_o), LW'(32'h400));
      chk("t1_wr", LW'(bus.mem_write_o), '0);
      ticks(9);
      mem_pulse(aa);
      chk("t1_ack", LW'(bus.p0_ack_o), LW'(1'b1));
      chk("t1_data", bus.p0_data_o, aa);
      chk("t1_p1ack", LW'(bus.p1_ack_o), '0);
      tick();
      chk("t1_ack_1cyc", LW'(bus.p0_ack_o), '0);
      ticks(2);

      // port 1 write: data_o must not change
      new_req(1, 1, 32'h0000_0020, ff55);
      drive();
      tick();
      chk("t2_wr", LW'(bus.mem_write_o), LW'(1'b1));
      chk("t2_wdata", bus.mem_data_o, ff55);
      ticks(3);
      mem_pulse(rand_line());
      chk("t2_ack", LW'(bus.p1_ack_o), LW'(1'b1));
      chk("t2_data_kept", bus.p1_data_o, '0);
      ticks(2);
      chk("t2_busy_low", LW'(bus.busy_o), '0);
      ticks(2);

      // simultaneous requests from a fresh reset
      do_reset();
`ifdef MEM_ARBITER_RR_EN
      need = 4; hold_req = 1;
`else
      need = 2; hold_req = 0;
`endif
      g0 = obs_grants.size();
      rand_req(0); rand_req(1); drive();
      auto_mem = 1;
      budget = 0;
      while (obs_grants.size() < g0 + need && budget < 300) begin
         tick();
         budget++;
      end
      chk("t3_grants_seen", LW'(obs_grants.size() >= g0 + need), LW'(1'b1));
      for (int i = 0; i < need; i++)
         if (g0 + i < obs_grants.size())
            chk("t3_grant_order", LW'(obs_grants[g0+i]), LW'(i % 2 == 0));
      hold_req = 0;
      ticks(40);

      // stray ack in IDLE, then p0 drops enable mid-WAIT
      auto_mem = 0;
      bus.mem_ack_i = 1'b0;
      ticks(2);
      mem_pulse(rand_line());
      chk("t4_stray_p0", LW'(bus.p0_ack_o), '0);
      chk("t4_stray_p1", LW'(bus.p1_ack_o), '0);
      new_req(0, 0, 32'h0000_1000, '0);
      drive();
      ticks(3);
      pend[0] = 0;
      drive();
      ticks(3);
      mem_pulse(bb);
      chk("t4_drop_ack", LW'(bus.p0_ack_o), LW'(1'b1));
      chk("t4_drop_data", bus.p0_data_o, bb);
      tick();
      chk("t4_drop_ack_once", LW'(bus.p0_ack_o), '0);
      ticks(2);

      // randomized traffic with stray acks
      auto_req = 1; auto_mem = 1; stray = 1;
      ticks(3000);
      auto_req = 0; stray = 0;
      ticks(40);

      // timeout: memory silent for TO WAIT cycles
      auto_mem = 0;
      bus.mem_ack_i = 1'b0;
      ticks(2);
      new_req(0, 0, 32'h0000_2000, '0);
      drive();
      tick();
      ticks(TO - 1);
      chk("t5_no_timeout_yet", LW'(bus.timeout_o), '0);
      tick();
      chk("t5_timeout", LW'(bus.timeout_o), LW'(1'b1));
      ticks(5);
      mem_pulse(aa);
      chk("t5_late_ack", LW'(bus.p0_ack_o), LW'(1'b1));
      chk("t5_sticky", LW'(bus.timeout_o), LW'(1'b1));
      ticks(3);

      // asynchronous reset in the middle of WAIT
      new_req(0, 0, 32'h0000_3000, '0);
      drive();
      ticks(3);
      #2;
      rst_n = 1'b0;
      #1;
      m_clear();
      check_all();
      chk("t6_async_en", LW'(bus.mem_enable_o), '0);
      chk("t6_async_to", LW'(bus.timeout_o), '0);
      tick();
      new_req(0, 0, 32'h0000_0800, '0);
      drive();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_regrant", LW'(bus.mem_addr_o), LW'(32'h800));
      ticks(4);
      mem_pulse(bb);
      chk("t6_ack", LW'(bus.p0_ack_o), LW'(1'b1));
      chk("t6_data", bus.p0_data_o, bb);
      ticks(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single 256-bit data memory port between two cache requesters: port 0 is the instruction cache, port 1 is the data cache.
- Each cache's memory-side outputs (enable/write/addr/data) connect to one requester port. The arbiter forwards one transaction at a time to the memory and returns the memory's ack and read line to the owning cache.
- Sits between the cache pair and Data_Memory inside the CPU top level.

Parameters:
- ADDR_W, 32, address width of all address ports.
- LINE_W, 256, cache line / memory data width.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit before timeout_o sets; 0 disables the timeout check.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- p0_enable_i  in  1  port 0 request; held high until p0_ack_o is seen.
- p0_write_i  in  1  port 0 transaction: 1=write line, 0=read line.
- p0_addr_i  in  ADDR_W  port 0 line address.
- p0_data_i  in  LINE_W  port 0 write line.
- p0_ack_o  out  1  one-cycle completion pulse to port 0.
- p0_data_o  out  LINE_W  port 0 read line; valid while p0_ack_o=1.
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o: same as port 0, for port 1.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write select.
- mem_addr_o  out  ADDR_W  memory address.
- mem_data_o  out  LINE_W  memory write line.
- mem_ack_i  in  1  memory completion pulse.
- mem_data_i  in  LINE_W  memory read line; valid with mem_ack_i.
- busy_o  out  1  high in every state except IDLE.
- timeout_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0, async): state=IDLE; all outputs 0 (mem_*, pN_ack_o, pN_data_o, busy_o, timeout_o); owner=0; wait counter=0; last_grant=0.
- All outputs are registered.
- States and transitions:
  - IDLE: at a clock edge with any pN_enable_i=1, select a winner. Register mem_enable_o=1 plus mem_write_o/mem_addr_o/mem_data_o from the winner's inputs; latch owner; clear counter; go to WAIT. With no request, stay in IDLE.
  - WAIT: mem_* outputs held constant; counter increments each cycle, saturating.
    - On mem_ack_i=1: mem_enable_o<=0, mem_write_o<=0, owner's ack<=1. Read transaction: owner's data_o<=mem_data_i. Write transaction: data_o unchanged. Go to RESP.
  - RESP: owner's ack stays high for exactly this one cycle; go to HOLD.
  - HOLD: ack low. One dead cycle so the requester can drop its enable; no arbitration in this cycle. Go to IDLE.
- Latency: request sampled at edge E0 puts mem_enable_o high after E0. mem_ack_i sampled at edge En puts pN_ack_o high during cycle En+1. Next grant is sampled no earlier than En+3.
- Default arbitration is fixed priority: port 1 (data cache) beats port 0.
- pN_data_o holds its last read line between completions.
- mem_ack_i outside WAIT is ignored.
- Requester drops enable during WAIT: the transaction still completes and the ack still pulses.
- The losing requester stays pending and needs no re-request.
- Timeout: if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES while in WAIT, timeout_o<=1 and stays 1 until reset. The arbiter keeps waiting for mem_ack_i.
- Reset mid-transaction abandons it: no ack is issued, and the requester re-requests after reset.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin arbitration. last_grant updates on each grant. On simultaneous requests, the port not equal to last_grant wins. Because last_grant resets to 0, port 1 wins the first tie after reset.
- Undefined: fixed priority, port 1 over port 0; last_grant logic is absent.

Test Plan:
- Single read on p0 (addr=0x0000_0400); memory acks 10 cycles later with data=0xAA..AA → mem_addr_o=0x400, mem_write_o=0; p0_ack_o pulses exactly 1 cycle; p0_data_o=0xAA..AA; p1_ack_o stays 0.
- p1 write (addr=0x20, data=0x55..55) → mem_write_o=1, mem_data_o=0x55..55; p1_ack_o pulses once; p1_data_o unchanged; busy_o low 3 cycles after mem_ack_i.
- p0 and p1 request in the same cycle, fixed priority → p1 served first, then p0 with no re-request. Under MEM_ARBITER_RR_EN: with both held continuously, grants alternate p1,p0,p1,p0.
- mem_ack_i pulsed while in IDLE, and p0 enable dropped mid-WAIT → stray ack produces no pN_ack_o; the dropped request still completes with p0_ack_o=1 once.
- TIMEOUT_CYCLES=8, memory never acks → timeout_o rises after 8 WAIT cycles and stays 1. A later ack still completes the transaction.
- rst_i asserted low during WAIT → all outputs 0 immediately (asynchronously); state IDLE; timeout_o cleared; subsequent p0 read works normally.
